// File: rtl/uart_pkg.sv
// uart_pkg: shared command layout and sequencer state encoding for the uart command path.
package uart_pkg;
    localparam int CMD_WIDTH = 16;
    localparam int READ_WIDTH = 8;
    localparam int RW_BIT = 15;
    localparam logic CMD_WR = 1'b1;
    localparam logic CMD_RD = 1'b0;
    localparam int ADDR_HI = 14;
    localparam int ADDR_LO = 8;
    localparam int DATA_HI = 7;
    localparam int DATA_LO = 0;
    localparam int TMR_W = 24;
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ISSUE, S_WAIT_RD, S_GAP, S_DONE} seq_state_t;
endpackage

// File: rtl/uart_seq_timer.sv
// uart_seq_timer: loadable down-counter; expired is high once the count reaches zero.
module uart_seq_timer #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);
    logic [W-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (cnt != '0) cnt <= cnt - 1'b1;
    assign expired = (cnt == '0);
endmodule

// File: rtl/uart_cmd_seq.sv
// uart_cmd_seq: walks a command table, issues commands to the uart engine and checks read-back bytes.
module uart_cmd_seq #(
    parameter int CMD_WIDTH  = uart_pkg::CMD_WIDTH,
    parameter int READ_WIDTH = uart_pkg::READ_WIDTH,
    parameter int NUM_CMDS   = 16,
    parameter int GAP_CYCLES = 2000,
    parameter int TIMEOUT    = 50000,
    parameter int IW         = $clog2(NUM_CMDS)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    output logic                            busy,
    output logic                            done,
    output logic                            err_timeout,
    output logic [7:0]                      mismatch_cnt,
    output logic [IW-1:0]                   first_bad_idx,
    output logic [IW-1:0]                   tbl_addr,
    input  logic [CMD_WIDTH+READ_WIDTH-1:0] tbl_data,
    output logic [CMD_WIDTH-1:0]            cmd_data,
    output logic                            cmd_vld,
    input  logic                            cmd_rdy,
    input  logic                            read_rdy,
    input  logic [READ_WIDTH-1:0]           read_data,
    output logic [READ_WIDTH-1:0]           last_rd
);
    import uart_pkg::*;

    seq_state_t             state;
    logic [IW-1:0]          idx;
    logic [READ_WIDTH-1:0]  exp_rd;
    logic                   ph;
    logic                   err_seen;
    logic                   tmr_load;
    logic                   tmr_expired;
    logic [TMR_W-1:0]       tmr_val;

    // The timer is reloaded on the edge that enters GAP or WAIT_RD.
    assign tmr_load = (state == S_ISSUE && cmd_rdy) || (state == S_WAIT_RD && read_rdy);
    assign tmr_val  = (state == S_ISSUE && cmd_data[RW_BIT] == CMD_RD) ? TMR_W'(TIMEOUT - 1)
                                                                       : TMR_W'(GAP_CYCLES - 1);

    uart_seq_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            idx           <= '0;
            ph            <= 1'b0;
            err_seen      <= 1'b0;
            exp_rd        <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err_timeout   <= 1'b0;
            mismatch_cnt  <= '0;
            first_bad_idx <= '0;
            tbl_addr      <= '0;
            cmd_data      <= '0;
            cmd_vld       <= 1'b0;
            last_rd       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy          <= 1'b1;
                        err_timeout   <= 1'b0;
                        mismatch_cnt  <= '0;
                        first_bad_idx <= '0;
                        err_seen      <= 1'b0;
                        idx           <= '0;
                        tbl_addr      <= '0;
                        ph            <= 1'b0;
                        state         <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    ph <= ~ph;
                    if (ph) begin
                        cmd_data <= tbl_data[CMD_WIDTH+READ_WIDTH-1:READ_WIDTH];
                        exp_rd   <= tbl_data[READ_WIDTH-1:0];
                        cmd_vld  <= 1'b1;
                        state    <= S_ISSUE;
                    end
                end
                S_ISSUE:
                    if (cmd_rdy) begin
                        cmd_vld <= 1'b0;
                        state   <= (cmd_data[RW_BIT] == CMD_WR) ? S_GAP : S_WAIT_RD;
                    end
                S_WAIT_RD:
                    if (read_rdy) begin
                        last_rd <= read_data;
                        if (read_data != exp_rd) begin
                            if (mismatch_cnt != 8'hFF) mismatch_cnt <= mismatch_cnt + 8'd1;
                            if (!err_seen) first_bad_idx <= idx;
                            err_seen <= 1'b1;
                        end
                        state <= S_GAP;
                    end else if (tmr_expired) begin
                        err_timeout <= 1'b1;
                        if (!err_seen) first_bad_idx <= idx;
                        err_seen <= 1'b1;
                        state    <= S_DONE;
                    end
                S_GAP:
                    if (tmr_expired) begin
                        if (idx == IW'(NUM_CMDS - 1)) begin
                            state <= S_DONE;
                        end else begin
                            idx      <= idx + 1'b1;
                            tbl_addr <= idx + 1'b1;
                            ph       <= 1'b0;
                            state    <= S_FETCH;
                        end
                    end
                S_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
